card_select_collector: RTL
==========================

// Module: card_select_collector
// PURPOSE
//   Collects three distinct card picks (indices 1..9) from the player.
//   Packs them as {third,second,first} into a 12-bit word. Offers the word to
//   the downstream card-clearing stage (its data_in) with a valid/ready handshake.
//   Sits between the debounced key/switch inputs and the card-clear/VGA plot path.
// PARAMETERS
//   TIMEOUT_CYCLES  50_000_000  idle cycles between picks before abort (SELECT_TIMEOUT_EN only)
//   TMO_W           26          width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//   clk            in   1   system clock; single clock domain
//   reset_n        in   1   asynchronous, active-low reset
//   card_in        in   4   card index from switches; valid 1..9
//   pick           in   1   pick button, active-high level, debounced and synchronous to clk
//   undo           in   1   pulse; removes the last accepted pick
//   clear_ready    in   1   downstream stage can accept data_out
//   data_out       out  12  {card3,card2,card1}; unused slots read 4'd0
//   data_valid     out  1   data_out holds a complete triple
//   pick_count     out  2   number of accepted picks, 0..3
//   selected_mask  out  9   bit k-1 set while card k is picked; used for highlight
//   reject         out  1   1-cycle pulse when a pick is refused
//   timeout        out  1   1-cycle pulse when a selection is aborted; tied 0 without macro
// BEHAVIOUR
//   - Reset (async assert, sync release): all outputs 0, state PICK1, pick_q 0, timer 0.
//   - pick_rise = pick & ~pick_q. pick_q is registered every cycle.
//   - Accept: pick_rise, card_in in 1..9, bit not set in selected_mask.
//     The card is written into slot[pick_count], the mask bit is set, and
//     pick_count is incremented. All updates are visible 1 cycle after the rising edge.
//   - Reject: pick_rise with card_in 0 or 10..15, or a card already picked.
//     reject pulses for 1 cycle. No other state changes.
//   - States PICK1 -> PICK2 -> PICK3 -> HOLD. Each transition happens on accept.
//   - HOLD: data_valid=1 and data_out is stable. pick and undo are ignored, with no reject.
//     On the cycle where data_valid & clear_ready, the transfer completes.
//     The next cycle the block returns to PICK1 with data_out, mask and count all 0.
//   - Undo: in PICK2 or PICK3, clears the last slot and its mask bit, decrements the
//     count, and moves back one state. No effect in PICK1 or HOLD.
//   - undo and pick_rise in the same cycle: undo wins. The pick is dropped, with no reject.
//   - clear_ready outside HOLD is ignored. data_valid never drops without a transfer,
//     except on reset.
//   - Reset mid-selection or in HOLD discards everything immediately.
// CONFIGURATION
//   SELECT_TIMEOUT_EN defined:
//     - In PICK2 and PICK3 the timer counts each cycle. It is cleared on accept, undo
//       and state entry.
//     - When the timer reaches TIMEOUT_CYCLES-1, the partial selection is discarded.
//       The block returns to PICK1 and timeout pulses for 1 cycle.
//     - The timer is idle in PICK1 and HOLD.
//   SELECT_TIMEOUT_EN undefined: no timer logic; timeout = 1'b0.
// STRUCTURE
//   - card_sel_pkg: state encodings (PICK1, PICK2, PICK3, HOLD), CARD_MIN=1, CARD_MAX=9,
//     SLOT_W=4, card-to-mask decode function.
//   - One sub-module, pick_edge_detect: pick_q register plus rise output.
//   - Everything else stays in this file.
// TESTING
//   - Reset, then picks 3,7,1 with clear_ready=0: data_out=12'h173, data_valid=1,
//     mask=9'b001000101. It holds for 20 cycles.
//   - Picks 5,5: the second pick pulses reject for 1 cycle; count stays 1, mask=9'b000010000.
//   - Pick with card_in=0, then with card_in=12: reject on each, state unchanged.
//   - Picks 2,4, undo, pick 6, pick 8: data_out=12'h862, mask bit 3 clear.
//   - undo and pick rise in the same cycle with count 1: count 0, no reject.
//   - HOLD, assert clear_ready for 1 cycle: next cycle data_valid=0, data_out=0, count=0.
//     A pick in HOLD produces no reject.
//   - SELECT_TIMEOUT_EN, TIMEOUT_CYCLES=8: pick 4, then idle 8 cycles.
//     timeout pulses, count 0, mask 0. Without the macro the block stays in PICK2.
//   - Assert reset_n low mid-PICK3, asynchronously off a clock edge: outputs go to 0
//     before the next clk edge.

Source files
------------

// File: rtl/card_select_collector_pkg.sv
// Shared types and constants for the card select collector.
// Card indices are 1..9; each card maps to one bit of the highlight mask.
package card_sel_pkg;

    typedef enum logic [1:0] {
        PICK1 = 2'd0,
        PICK2 = 2'd1,
        PICK3 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int unsigned CARD_MIN = 1;
    localparam int unsigned CARD_MAX = 9;
    localparam int unsigned SLOT_W   = 4;
    localparam int unsigned MASK_W   = CARD_MAX;

    // One-hot highlight bit for a card; out-of-range indices decode to zero.
    function automatic logic [MASK_W-1:0] card_to_mask(input logic [SLOT_W-1:0] card);
        logic [MASK_W-1:0] m;
        m = '0;
        if (card >= SLOT_W'(CARD_MIN) && card <= SLOT_W'(CARD_MAX))
            m = MASK_W'(1) << (card - SLOT_W'(1));
        return m;
    endfunction

endpackage

// File: rtl/card_select_collector_if.sv
// Valid/ready handshake carrying the packed card triple to the card-clearing stage.
interface card_select_collector_if;
    logic [11:0] data_out;
    logic        data_valid;
    logic        clear_ready;

    modport master (output data_out, output data_valid, input clear_ready);
    modport slave  (input data_out, input data_valid, output clear_ready);
endinterface

// File: rtl/card_select_collector_pick_edge_detect.sv
// Rising-edge detector for the debounced pick button.
module pick_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic pick,
    output logic rise
);
    logic pick_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pick_q <= 1'b0;
        else          pick_q <= pick;
    end

    assign rise = pick & ~pick_q;
endmodule

// File: rtl/card_select_collector.sv
// Collects three distinct card picks and offers {third,second,first} downstream.
// Optional idle-abort timer between picks is enabled by SELECT_TIMEOUT_EN.
module card_select_collector
    import card_sel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TMO_W          = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SLOT_W-1:0]     card_in,
    input  logic                  pick,
    input  logic                  undo,
    card_select_collector_if.master bus,
    output logic [1:0]            pick_count,
    output logic [MASK_W-1:0]     selected_mask,
    output logic                  reject,
    output logic                  timeout
);
    state_t                   state;
    logic [2:0][SLOT_W-1:0]   slots;
    logic                     data_valid;
    logic                     pick_rise;
    logic [MASK_W-1:0]        card_bit;
    logic [1:0]               undo_idx;
    logic                     do_undo;
    logic                     do_pick;
    logic                     do_accept;
    logic                     do_reject;
    logic                     do_timeout;

    pick_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .pick    (pick),
        .rise    (pick_rise)
    );

    // Undo beats a simultaneous pick; HOLD ignores both without a reject.
    always_comb begin
        card_bit  = card_to_mask(card_in);
        undo_idx  = pick_count - 2'd1;
        do_undo   = undo && (state == PICK2 || state == PICK3);
        do_pick   = pick_rise && !undo && (state != HOLD);
        do_accept = do_pick && (card_bit != '0) && ((selected_mask & card_bit) == '0);
        do_reject = do_pick && !do_accept;
    end

`ifdef SELECT_TIMEOUT_EN
    logic [TMO_W-1:0] timer;

    assign do_timeout = (state == PICK2 || state == PICK3) && !do_accept && !do_undo
                        && (timer == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= do_timeout;
            if (state == PICK1 || state == HOLD || do_accept || do_undo || do_timeout)
                timer <= '0;
            else
                timer <= timer + TMO_W'(1);
        end
    end
`else
    assign do_timeout = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PICK1;
            slots         <= '0;
            selected_mask <= '0;
            pick_count    <= '0;
            data_valid    <= 1'b0;
            reject        <= 1'b0;
        end else begin
            reject <= do_reject;
            if (state == HOLD) begin
                if (bus.clear_ready) begin
                    state         <= PICK1;
                    slots         <= '0;
                    selected_mask <= '0;
                    pick_count    <= '0;
                    data_valid    <= 1'b0;
                end
            end else if (do_undo) begin
                slots[undo_idx] <= '0;
                selected_mask   <= selected_mask & ~card_to_mask(slots[undo_idx]);
                pick_count      <= pick_count - 2'd1;
                state           <= (state == PICK3) ? PICK2 : PICK1;
            end else if (do_accept) begin
                slots[pick_count] <= card_in;
                selected_mask     <= selected_mask | card_bit;
                pick_count        <= pick_count + 2'd1;
                unique case (state)
                    PICK1:   state <= PICK2;
                    PICK2:   state <= PICK3;
                    default: begin
                        state      <= HOLD;
                        data_valid <= 1'b1;
                    end
                endcase
            end else if (do_timeout) begin
                state         <= PICK1;
                slots         <= '0;
                selected_mask <= '0;
                pick_count    <= '0;
            end
        end
    end

    assign bus.data_out   = slots;
    assign bus.data_valid = data_valid;
endmodule
